// File: rtl/serial_arith_pkg.sv
// Shared types and constants for the serial arithmetic blocks.
// Holds the operand serializer FSM encoding and the default operand width.
package serial_arith_pkg;

  localparam int unsigned DefaultWidth = 8;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StShift,
    StDone
  } state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, LSB first, zero-filled from the top.
// Load has priority over shift.
module piso_shift_reg
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             dout
);

  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (load) begin
      data_d = din;
    end else if (shift) begin
      data_d = {1'b0, data_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign dout = data_q[0];

endmodule

// File: rtl/operand_serializer.sv
// Accepts a parallel operand pair plus carry-in and streams it LSB first to a
// downstream serial adder: clear cycle, WIDTH bit cycles, then a done pulse.
module operand_serializer
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin_in,
  output logic             adder_rst,
  output logic             a,
  output logic             b,
  output logic             cin,
  output logic             bit_valid,
  output logic             bit_last,
  output logic             done
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            cin_q, cin_d;
  logic            load, shift;
  logic            a_bit, b_bit;
  logic            in_shift;

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_a_reg (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(shift),
    .din  (a_in),
    .dout (a_bit)
  );

  piso_shift_reg #(
    .WIDTH(WIDTH)
  ) u_b_reg (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .shift(shift),
    .din  (b_in),
    .dout (b_bit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cin_d   = cin_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          cin_d   = cin_in;
          cnt_d   = '0;
          state_d = StClear;
        end
      end
      StClear: state_d = StShift;
      StShift: begin
        shift = 1'b1;
        // Counter ends at WIDTH, which fits in CntW bits, so it never wraps.
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastBit) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cin_q   <= cin_d;
    end
  end

  // Every output is decoded from registered state only.
  assign in_shift  = (state_q == StShift);
  assign in_ready  = (state_q == StIdle);
  assign adder_rst = (state_q == StClear);
  assign done      = (state_q == StDone);
  assign bit_valid = in_shift;
  assign a         = in_shift & a_bit;
  assign b         = in_shift & b_bit;
  assign cin       = in_shift & (cnt_q == '0) & cin_q;
  assign bit_last  = in_shift & (cnt_q == LastBit);

endmodule
